// File: rtl/alu_operand_loader.sv
// Debounced single-button loader for ALU operands A, B and opcode, with result/flag capture.
// Optional macro LONG_PRESS_CLEAR_EN: holding the button HOLD_CYCLES clears operands and restarts at A.
module alu_operand_loader #(
  parameter int Nbit            = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_n,
  input  logic [Nbit-1:0] sw,
  input  logic [3:0]      op_sw,
  output logic [Nbit-1:0] alu_a,
  output logic [Nbit-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [Nbit-1:0] alu_result,
  input  logic [3:0]      alu_nzcv,
  output logic [Nbit-1:0] res,
  output logic [3:0]      res_flags,
  output logic            res_valid,
  output logic [2:0]      state_led
);
  localparam int         DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [3:0] OP_ADD = 4'b1111;

  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_SHOW} state_t;

  state_t            state_q, state_d;
  logic              btn_meta_p0, btn_sync_p1, btn_stable;
  logic [DCNT_W-1:0] dcnt;
  logic              differ, settle, press, clear;
  logic              load_a, load_b, load_op, capture, drop_valid;

  // stage 0/1: two-flop synchronizer, idle level is released (1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_p0 <= 1'b1;
      btn_sync_p1 <= 1'b1;
    end else begin
      btn_meta_p0 <= btn_n;
      btn_sync_p1 <= btn_meta_p0;
    end
  end

  // debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive differing samples
  assign differ = (btn_sync_p1 != btn_stable);
  assign settle = differ && (dcnt == DCNT_W'(DEBOUNCE_CYCLES - 1));
  assign press  = settle && !btn_sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt       <= '0;
      btn_stable <= 1'b1;
    end else if (!differ) begin
      dcnt <= '0;
    end else if (settle) begin
      btn_stable <= btn_sync_p1;
      dcnt       <= '0;
    end else begin
      dcnt <= dcnt + DCNT_W'(1);
    end
  end

`ifdef LONG_PRESS_CLEAR_EN
  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
  logic [HCNT_W-1:0] hcnt;

  // hold counter saturates, so a single hold yields exactly one clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
    end else if (btn_stable) begin
      hcnt <= '0;
    end else if (hcnt != HCNT_W'(HOLD_CYCLES)) begin
      hcnt <= hcnt + HCNT_W'(1);
    end
  end

  assign clear = !btn_stable && (hcnt == HCNT_W'(HOLD_CYCLES - 1));
`else
  assign clear = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    capture    = 1'b0;
    drop_valid = 1'b0;
    case (state_q)
      S_A:    if (press) begin load_a  = 1'b1; state_d = S_B;    end
      S_B:    if (press) begin load_b  = 1'b1; state_d = S_OP;   end
      S_OP:   if (press) begin load_op = 1'b1; state_d = S_EXEC; end
      S_EXEC: begin capture = 1'b1; state_d = S_SHOW; end
      S_SHOW: if (press) begin drop_valid = 1'b1; state_d = S_A; end
      default: state_d = S_A;
    endcase
    if (clear) state_d = S_A;
  end

  always_comb begin
    state_led = 3'b000;
    case (state_q)
      S_A:     state_led = 3'b001;
      S_B:     state_led = 3'b010;
      S_OP:    state_led = 3'b100;
      default: state_led = 3'b000;
    endcase
  end

  // operand/opcode registers feeding the combinational ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_ADD;
      res_valid <= 1'b0;
    end else if (clear) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_ADD;
      res_valid <= 1'b0;
    end else begin
      if (load_a)     alu_a     <= sw;
      if (load_b)     alu_b     <= sw;
      if (load_op)    alu_op    <= op_sw;
      if (capture)    res_valid <= 1'b1;
      if (drop_valid) res_valid <= 1'b0;
    end
  end

  // result holding register keeps its value until the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res       <= '0;
      res_flags <= '0;
    end else if (capture) begin
      res       <= alu_result;
      res_flags <= alu_nzcv;
    end
  end

endmodule
